serial_link_endpoint: RTL and testbench

Device-side endpoint for the board's byte link: `rxdata`/`rxready` in, `txdata`/`txclk`/`rxclk` out, `txready` in. It accepts bytes the host offers on the receive channel and sends bytes the design queues on the transmit channel. Each direction has a four-phase handshake and a small FIFO. It sits inside `top`, between the board link pins and user logic.

---
 rtl/link_pkg.sv | 17 +
 rtl/byte_fifo.sv | 62 ++++++
 rtl/serial_link_endpoint.sv | 108 ++++++++++
 tb/tb_serial_link_endpoint.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared types and widths for the serial link endpoint.
package link_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with wrap-bit pointers and registered empty/full flags.
// A pop on a full FIFO frees the slot for a push on the same edge; a pop on an
// empty FIFO is ignored.
module byte_fifo
  import link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              push,
  input  logic              pop,
  output logic [BYTE_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] WRAP_BIT = {1'b1, {AW{1'b0}}};

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [AW:0]       wptr_n;
  logic [AW:0]       rptr_n;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign wptr_n  = do_push ? (wptr + PTR_ONE) : wptr;
  assign rptr_n  = do_pop  ? (rptr + PTR_ONE) : rptr;

  // Head is forced to zero while empty so the output is defined after reset.
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer and flag update; flags are compared on the next pointer values so
  // they change on the same edge as the push or pop.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      empty <= (wptr_n == rptr_n);
      full  <= ((wptr_n ^ rptr_n) == WRAP_BIT);
    end
  end

  // Storage write; data is not reset, readers are gated by the empty flag.
  always_ff @(posedge hz100) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/serial_link_endpoint.sv
// Device-side byte link endpoint: four-phase RX and TX handshakes, each
// buffered by a byte_fifo, plus a sticky TX overrun flag.
module serial_link_endpoint
  import link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rxdata,
  input  logic              rxready,
  output logic              rxclk,
  input  logic              txready,
  output logic [BYTE_W-1:0] txdata,
  output logic              txclk,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              rx_valid,
  input  logic              rx_take,
  input  logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_push,
  output logic              tx_full,
  output logic              overrun
);

  rx_state_t         rx_state;
  tx_state_t         tx_state;
  logic              rx_push;
  logic              rx_empty;
  logic              rx_full;
  logic              tx_pop;
  logic              tx_empty;
  logic [BYTE_W-1:0] tx_head;

  // Strobes decode straight from state so an async reset drops them at once.
  assign rxclk    = (rx_state == RX_ACK);
  assign txclk    = (tx_state == TX_SEND);
  assign rx_valid = ~rx_empty;

  // A byte is captured only on the IDLE->ACK edge; a full FIFO withholds the ack.
  assign rx_push = (rx_state == RX_IDLE) & rxready & ~rx_full;
  // The TX head is released when the host acknowledges by dropping txready.
  assign tx_pop  = (tx_state == TX_SEND) & ~txready;

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .hz100 (hz100),
    .reset (reset),
    .wdata (rxdata),
    .push  (rx_push),
    .pop   (rx_take),
    .rdata (rx_byte),
    .empty (rx_empty),
    .full  (rx_full)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .hz100 (hz100),
    .reset (reset),
    .wdata (tx_byte),
    .push  (tx_push),
    .pop   (tx_pop),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  // RX handshake: ack while the host holds rxready, release when it drops.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_push)  rx_state <= RX_ACK;
        RX_ACK:  if (!rxready) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // TX handshake and output byte register; txdata only loads on IDLE->SEND.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      txdata   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty && txready) begin
            tx_state <= TX_SEND;
            txdata   <= tx_head;
          end
        end
        TX_SEND: if (!txready) tx_state <= TX_WAIT;
        TX_WAIT: if (txready)  tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Sticky overrun: a push is lost only when full and not freed by a same-edge pop.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (tx_push && tx_full && !tx_pop) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_link_endpoint.sv
// Self-checking bench for serial_link_endpoint with RX/TX scoreboard queues.
module tb_serial_link_endpoint;

  logic       hz100 = 1'b0;
  logic       reset;
  logic [7:0] rxdata;
  logic       rxready;
  logic       rxclk;
  logic       txready;
  logic [7:0] txdata;
  logic       txclk;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_take;
  logic [7:0] tx_byte;
  logic       tx_push;
  logic       tx_full;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  serial_link_endpoint #(.DEPTH(4)) dut (
    .hz100    (hz100),
    .reset    (reset),
    .rxdata   (rxdata),
    .rxready  (rxready),
    .rxclk    (rxclk),
    .txready  (txready),
    .txdata   (txdata),
    .txclk    (txclk),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_take  (rx_take),
    .tx_byte  (tx_byte),
    .tx_push  (tx_push),
    .tx_full  (tx_full),
    .overrun  (overrun)
  );

  always #5 hz100 = ~hz100;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  // Host offers one RX byte and completes the four-phase handshake.
  task automatic rx_host_send(input logic [7:0] b, output bit acked);
    acked = 1'b0;
    rxdata = b;
    rxready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rxclk === 1'b1) begin
        acked = 1'b1;
        break;
      end
    end
    rxready = 1'b0;
    tick();
  endtask

  // Host accepts one TX byte; reports the byte, whether it arrived, and whether
  // txclk fell one edge after txready dropped with txdata held.
  task automatic tx_host_recv(output logic [7:0] b, output bit got, output bit fell);
    got = 1'b0;
    fell = 1'b0;
    b = '0;
    txready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (txclk === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (got) b = txdata;
    txready = 1'b0;
    tick();
    fell = got && (txclk === 1'b0) && (txdata === b);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rxready = 1'b1;
    txready = 1'b1;
    rxdata = 8'h3C;
    rx_take = 1'b0;
    tx_push = 1'b0;
    tx_byte = 8'h00;
    tick(); tick(); tick();
    checks++;
    if ({rxclk, txclk, txdata, rx_byte, rx_valid, tx_full, overrun} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rxclk=%b txclk=%b txdata=%h rx_byte=%h rx_valid=%b tx_full=%b overrun=%b, expected all 0",
               rxclk, txclk, txdata, rx_byte, rx_valid, tx_full, overrun);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (rxclk !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ack: rxclk=%b expected 1", rxclk);
    end
    rx_q.push_back(8'h3C);
    rxready = 1'b0;
    txready = 1'b0;
    tick();
    checks++;
    if (rx_byte !== rx_q[0]) begin
      errors++;
      $display("FAIL reset_rx_byte: got %h expected %h", rx_byte, rx_q[0]);
    end
    void'(rx_q.pop_front());
    rx_take = 1'b1;
    tick();
    rx_take = 1'b0;
  endtask

  task automatic test_rx_single();
    logic [7:0] exp;
    rx_q.push_back(8'hA5);
    rxdata = 8'hA5;
    rxready = 1'b1;
    tick();
    exp = rx_q.pop_front();
    checks++;
    if ({rxclk, rx_valid, rx_byte} !== {1'b1, 1'b1, exp}) begin
      errors++;
      $display("FAIL rx_single_ack: got rxclk=%b rx_valid=%b rx_byte=%h expected 1 1 %h", rxclk, rx_valid, rx_byte, exp);
    end
    tick();
    checks++;
    if (rxclk !== 1'b1) begin
      errors++;
      $display("FAIL rx_single_hold: rxclk=%b expected 1", rxclk);
    end
    rxready = 1'b0;
    tick();
    checks++;
    if (rxclk !== 1'b0) begin
      errors++;
      $display("FAIL rx_single_release: rxclk=%b expected 0", rxclk);
    end
    rx_take = 1'b1;
    tick();
    rx_take = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_single_take: rx_valid=%b expected 0", rx_valid);
    end
  endtask

  task automatic test_rx_full();
    bit ok;
    logic [7:0] exp;
    for (int i = 1; i <= 4; i++) begin
      rx_host_send(8'(i), ok);
      rx_q.push_back(8'(i));
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rx_full_fill_ack: byte %0d not acked, expected ack", i);
      end
    end
    rxdata = 8'h05;
    rxready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (rxclk !== 1'b0) begin
      errors++;
      $display("FAIL rx_full_backpressure: rxclk=%b expected 0", rxclk);
    end
    exp = rx_q.pop_front();
    checks++;
    if (rx_byte !== exp) begin
      errors++;
      $display("FAIL rx_full_head: got %h expected %h", rx_byte, exp);
    end
    rx_take = 1'b1;
    tick();
    rx_take = 1'b0;
    checks++;
    if (rxclk !== 1'b0) begin
      errors++;
      $display("FAIL rx_full_pop_edge: rxclk=%b expected 0", rxclk);
    end
    tick();
    rx_q.push_back(8'h05);
    checks++;
    if (rxclk !== 1'b1) begin
      errors++;
      $display("FAIL rx_full_fifth_ack: rxclk=%b expected 1", rxclk);
    end
    rxready = 1'b0;
    tick();
    rx_take = 1'b1;
    while (rx_q.size() > 0) begin
      exp = rx_q.pop_front();
      checks++;
      if ({rx_valid, rx_byte} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL rx_full_drain: got valid=%b byte=%h expected 1 %h", rx_valid, rx_byte, exp);
      end
      tick();
    end
    rx_take = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_full_empty: rx_valid=%b expected 0", rx_valid);
    end
  endtask

  task automatic test_tx_order();
    logic [7:0] b;
    logic [7:0] exp;
    bit got;
    bit fell;
    txready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tx_byte = 8'(i * 16);
      tx_push = 1'b1;
      tx_q.push_back(8'(i * 16));
      tick();
    end
    tx_push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_host_recv(b, got, fell);
      exp = tx_q.pop_front();
      checks++;
      if (!got || b !== exp) begin
        errors++;
        $display("FAIL tx_order_byte: got %h (strobe=%b) expected %h", b, got, exp);
      end
      checks++;
      if (!fell) begin
        errors++;
        $display("FAIL tx_order_fall: txclk=%b txdata=%h expected 0 and %h held", txclk, txdata, b);
      end
    end
  endtask

  task automatic test_full_overrun();
    logic [7:0] b;
    logic [7:0] exp;
    bit got;
    bit fell;
    txready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_byte = 8'hA1 + 8'(i);
      tx_push = 1'b1;
      tx_q.push_back(8'hA1 + 8'(i));
      tick();
    end
    tx_push = 1'b0;
    checks++;
    if (tx_full !== 1'b1) begin
      errors++;
      $display("FAIL ovr_filled: tx_full=%b expected 1", tx_full);
    end
    txready = 1'b1;
    tick();
    tick();
    exp = tx_q.pop_front();
    checks++;
    if ({txclk, txdata} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL ovr_send_head: got txclk=%b txdata=%h expected 1 %h", txclk, txdata, exp);
    end
    txready = 1'b0;
    tx_byte = 8'h77;
    tx_push = 1'b1;
    tx_q.push_back(8'h77);
    tick();
    tx_push = 1'b0;
    checks++;
    if ({txclk, tx_full, overrun} !== 3'b010) begin
      errors++;
      $display("FAIL ovr_push_pop: got txclk=%b tx_full=%b overrun=%b expected 0 1 0", txclk, tx_full, overrun);
    end
    tx_byte = 8'h88;
    tx_push = 1'b1;
    tick();
    tx_push = 1'b0;
    checks++;
    if ({tx_full, overrun} !== 2'b11) begin
      errors++;
      $display("FAIL ovr_drop: got tx_full=%b overrun=%b expected 1 1", tx_full, overrun);
    end
    while (tx_q.size() > 0) begin
      tx_host_recv(b, got, fell);
      exp = tx_q.pop_front();
      checks++;
      if (!got || b !== exp) begin
        errors++;
        $display("FAIL ovr_drain: got %h (strobe=%b) expected %h", b, got, exp);
      end
    end
    txready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (txclk !== 1'b0) begin
        errors++;
        $display("FAIL ovr_no_extra: txclk=%b expected 0 (dropped byte sent)", txclk);
      end
    end
    txready = 1'b0;
    checks++;
    if ({overrun, tx_full} !== 2'b10) begin
      errors++;
      $display("FAIL ovr_sticky: got overrun=%b tx_full=%b expected 1 0", overrun, tx_full);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    txready = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      tx_byte = 8'hB1 + 8'(i);
      tx_push = 1'b1;
      tick();
    end
    tx_push = 1'b0;
    txready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (txclk === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL mid_enter_send: txclk never rose, expected 1");
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({txclk, rxclk, tx_full, overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async_drop: got txclk=%b rxclk=%b tx_full=%b overrun=%b expected 0 0 0 0",
               txclk, rxclk, tx_full, overrun);
    end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (txclk !== 1'b0) begin
        errors++;
        $display("FAIL mid_discard: txclk=%b expected 0 after reset", txclk);
      end
    end
    txready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rx_single();
    test_rx_full();
    test_tx_order();
    test_full_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
